// File: rtl/caminho_pkg.sv
// Shared definitions for the path-construction stage: FSM state codes,
// default sizes, the "no parent" value and the sp/length width helper.
package caminho_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LER    = 3'd1;
    localparam logic [2:0] ST_ESPERA = 3'd2;
    localparam logic [2:0] ST_EMITIR = 3'd3;
    localparam logic [2:0] ST_ERRO   = 3'd4;

    localparam int ADDR_WIDTH_DEF = 8;
    localparam int MAX_PATH_DEF   = 64;
    localparam logic [ADDR_WIDTH_DEF-1:0] NO_PAI_DEF = {ADDR_WIDTH_DEF{1'b1}};

    // Width able to hold every count from 0 to max_path inclusive.
    function automatic int sp_width(input int max_path);
        return $clog2(max_path + 1);
    endfunction

endpackage

// File: rtl/construtor_caminho_if.sv
// Path output stream: a beat transfers when caminho_valido_out && caminho_ler_in;
// the source holds caminho_no_out stable while valid is high and ready is low.
interface construtor_caminho_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] caminho_no_out;
    logic                  caminho_valido_out;
    logic                  caminho_ler_in;

    modport master (output caminho_no_out, output caminho_valido_out, input caminho_ler_in);
    modport slave  (input caminho_no_out, input caminho_valido_out, output caminho_ler_in);
endinterface

// File: rtl/pilha_caminho.sv
// Node storage for the path walk: append-only array with clear, indexed
// combinational read and full/empty flags. Clear and push together restart at slot 0.
module pilha_caminho
    import caminho_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MAX_PATH   = MAX_PATH_DEF,
    localparam int SP_W      = sp_width(MAX_PATH),
    localparam int IDX_W     = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_dado,
    input  logic [SP_W-1:0]       i_idx,
    output logic [ADDR_WIDTH-1:0] o_dado,
    output logic [SP_W-1:0]       o_sp,
    output logic                  o_cheio,
    output logic                  o_vazio
);
    logic [ADDR_WIDTH-1:0] r_mem [MAX_PATH];
    logic [SP_W-1:0]       r_sp;
    logic [SP_W-1:0]       w_base;
    logic                  w_escreve;

    assign w_base    = i_clear ? '0 : r_sp;
    assign w_escreve = i_push && (w_base != SP_W'(MAX_PATH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_escreve) begin
            r_sp <= w_base + SP_W'(1);
        end else begin
            r_sp <= w_base;
        end
    end

    always_ff @(posedge clk) begin
        if (w_escreve) begin
            r_mem[w_base[IDX_W-1:0]] <= i_dado;
        end
    end

    assign o_dado  = r_mem[i_idx[IDX_W-1:0]];
    assign o_sp    = r_sp;
    assign o_cheio = (r_sp == SP_W'(MAX_PATH));
    assign o_vazio = (r_sp == '0);
endmodule

// File: rtl/construtor_caminho.sv
// Walks the parent table from destination back to source, stores the path and streams it.
// CAMINHO_ORDEM_FONTE_EN defined: stream source-first; undefined: destination-first.
module construtor_caminho
    import caminho_pkg::*;
#(
    parameter int ADDR_WIDTH              = ADDR_WIDTH_DEF,
    parameter int MAX_PATH                = MAX_PATH_DEF,
    parameter logic [ADDR_WIDTH-1:0] NO_PAI = {ADDR_WIDTH{1'b1}},
    localparam int SP_W                   = sp_width(MAX_PATH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  construir_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  pai_rd_out,
    output logic [ADDR_WIDTH-1:0] pai_addr_out,
    input  logic [ADDR_WIDTH-1:0] pai_data_in,
    construtor_caminho_if.master  caminho,
    output logic                  caminho_pronto_out,
    output logic [SP_W-1:0]       comprimento_out,
    output logic                  erro_out,
    output logic [2:0]            estado_out
);
    logic [2:0]            r_estado, w_prox;
    logic [ADDR_WIDTH-1:0] r_fonte, r_cur;
    logic [SP_W-1:0]       r_idx, r_comp;
    logic                  r_erro;

    logic                  w_push, w_clear, w_cheio, w_vazio, w_ultimo, w_transf, w_inicio;
    logic                  w_falha;
    logic [ADDR_WIDTH-1:0] w_push_dado, w_rd_dado;
    logic [SP_W-1:0]       w_sp;

    pilha_caminho #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_PATH(MAX_PATH)) u_pilha (
        .clk(clk), .rst(rst), .i_push(w_push), .i_clear(w_clear), .i_dado(w_push_dado),
        .i_idx(r_idx), .o_dado(w_rd_dado), .o_sp(w_sp), .o_cheio(w_cheio), .o_vazio(w_vazio)
    );

    assign w_inicio = (r_estado == ST_IDLE) && construir_in;
    assign w_falha  = (pai_data_in == NO_PAI) || w_cheio;
    assign w_transf = (r_estado == ST_EMITIR) && !w_vazio && caminho.caminho_ler_in;
`ifdef CAMINHO_ORDEM_FONTE_EN
    assign w_ultimo = (r_idx == '0);
`else
    assign w_ultimo = (r_idx == w_sp - SP_W'(1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_estado <= ST_IDLE;
        else     r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            ST_IDLE:   if (construir_in) w_prox = (destino_in == fonte_in) ? ST_EMITIR : ST_LER;
            ST_LER:    w_prox = ST_ESPERA;
            ST_ESPERA: begin
                if (w_falha)                    w_prox = ST_ERRO;
                else if (pai_data_in == r_fonte) w_prox = ST_EMITIR;
                else                             w_prox = ST_LER;
            end
            ST_EMITIR: if (w_transf && w_ultimo) w_prox = ST_IDLE;
            ST_ERRO:   w_prox = ST_IDLE;
            default:   w_prox = ST_IDLE;
        endcase
    end

    always_comb begin
        pai_rd_out                 = (r_estado == ST_LER);
        pai_addr_out               = (r_estado == ST_LER) ? r_cur : '0;
        caminho_pronto_out         = (r_estado == ST_EMITIR);
        caminho.caminho_valido_out = (r_estado == ST_EMITIR) && !w_vazio;
        caminho.caminho_no_out     = (r_estado == ST_EMITIR) ? w_rd_dado : '0;
        w_push                     = w_inicio || ((r_estado == ST_ESPERA) && !w_falha);
        w_push_dado                = (r_estado == ST_IDLE) ? destino_in : pai_data_in;
        w_clear                    = w_inicio || (w_transf && w_ultimo);
    end

    // Walk/stream datapath; the read index is positioned on entry to EMITIR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fonte <= '0;
            r_cur   <= '0;
            r_idx   <= '0;
            r_comp  <= '0;
            r_erro  <= 1'b0;
        end else begin
            case (r_estado)
                ST_IDLE: if (construir_in) begin
                    r_fonte <= fonte_in;
                    r_cur   <= destino_in;
                    r_idx   <= '0;
                    r_comp  <= SP_W'(1);
                    r_erro  <= 1'b0;
                end
                ST_ESPERA: begin
                    if (w_falha) begin
                        r_erro <= 1'b1;
                    end else begin
                        r_comp <= r_comp + SP_W'(1);
                        r_cur  <= pai_data_in;
`ifdef CAMINHO_ORDEM_FONTE_EN
                        r_idx  <= w_sp;
`endif
                    end
                end
                ST_EMITIR: if (w_transf && !w_ultimo) begin
`ifdef CAMINHO_ORDEM_FONTE_EN
                    r_idx <= r_idx - SP_W'(1);
`else
                    r_idx <= r_idx + SP_W'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign comprimento_out = r_comp;
    assign erro_out        = r_erro;
    assign estado_out      = r_estado;
endmodule
